// File: rtl/piradip_axilite_regfile_pkg.sv
// Shared types and helpers for the PiRadIP AXI4-Lite register file.
// Helpers operate on the widest supported bus (64 bits); callers zero-extend
// narrower values and keep only the low DATA_WIDTH bits of the result.
package piradip_axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int MAX_DW   = 64;
    localparam int MAX_STRB = MAX_DW / 8;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0]   old_data,
        input logic [MAX_DW-1:0]   new_data,
        input logic [MAX_STRB-1:0] strb
    );
        logic [MAX_DW-1:0] merged;
        merged = old_data;
        for (int k = 0; k < MAX_STRB; k++) begin
            if (strb[k]) begin
                merged[k*8 +: 8] = new_data[k*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Word index of a byte address; the byte-offset bits are dropped.
    function automatic logic [31:0] reg_index(
        input logic [MAX_DW-1:0] addr,
        input int                data_width
    );
        if (data_width == 64) begin
            return 32'(addr >> 3);
        end
        return 32'(addr >> 2);
    endfunction

endpackage

// File: rtl/piradip_axilite_regfile_hold.sv
// One-entry valid/ready holding register. Accepts one beat while empty
// (ready = !full) and keeps it until the consumer pulses i_clear.
module piradip_axil_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    input  logic         i_clear,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    // Capture a beat when empty; release it on clear (only issued while full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = !r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/piradip_axilite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS control (writable) or status
// (read-only, from reg_in) registers with per-register write/read strobes.
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid && ready; valid never waits on ready, and payload is held while
// valid is high and ready low.
module piradip_axilite_regfile
    import piradip_axilite_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 8,
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic                       w_aw_full;
    logic                       w_w_full;
    logic [ADDR_WIDTH-1:0]      w_aw_addr;
    logic [DATA_WIDTH+STRB_W-1:0] w_w_payload;
    logic [DATA_WIDTH-1:0]      w_wdata;
    logic [STRB_W-1:0]          w_wstrb;
    logic                       w_commit;
    logic [MAX_DW-1:0]          w_aw_addr64;
    logic [MAX_DW-1:0]          w_ar_addr64;
    logic [MAX_DW-1:0]          w_wdata64;
    logic [MAX_STRB-1:0]        w_wstrb8;
    logic [MAX_DW-1:0]          w_wr_old64;
    logic [MAX_DW-1:0]          w_merged64;
    logic [31:0]                w_wr_idx;
    logic [31:0]                w_rd_idx;
    logic                       w_wr_ok;
    logic                       w_rd_ok;
    logic [NUM_REGS-1:0]        w_wr_sel;
    logic [NUM_REGS-1:0]        w_rd_sel;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_unused;

    logic                       r_bvalid;
    logic [1:0]                 r_bresp;
    logic [NUM_REGS-1:0]        r_wr_pulse;
    logic                       r_rvalid;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [1:0]                 r_rresp;
    logic [NUM_REGS-1:0]        r_rd_pulse;

    // AW and W are buffered independently so either may arrive first.
    piradip_axil_hold #(.W(ADDR_WIDTH)) u_aw_hold (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (awvalid),
        .o_ready (awready),
        .i_data  (awaddr),
        .i_clear (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    piradip_axil_hold #(.W(DATA_WIDTH + STRB_W)) u_w_hold (
        .clk     (aclk),
        .rst     (areset),
        .i_valid (wvalid),
        .o_ready (wready),
        .i_data  ({wstrb, wdata}),
        .i_clear (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_payload)
    );

    assign {w_wstrb, w_wdata} = w_w_payload;

    // A write commits once both halves are held and no response is pending.
    assign w_commit = w_aw_full && w_w_full && !r_bvalid;

    // Widen addresses and data to the helper functions' fixed width.
    always_comb begin
        w_aw_addr64                   = '0;
        w_aw_addr64[ADDR_WIDTH-1:0]   = w_aw_addr;
        w_ar_addr64                   = '0;
        w_ar_addr64[ADDR_WIDTH-1:0]   = araddr;
        w_wdata64                     = '0;
        w_wdata64[DATA_WIDTH-1:0]     = w_wdata;
        w_wstrb8                      = '0;
        w_wstrb8[STRB_W-1:0]          = w_wstrb;
    end

    assign w_wr_idx = reg_index(w_aw_addr64, DATA_WIDTH);
    assign w_rd_idx = reg_index(w_ar_addr64, DATA_WIDTH);

    // Decode write/read targets; only writable in-range indices may be written.
    always_comb begin
        w_wr_ok    = 1'b0;
        w_wr_sel   = '0;
        w_wr_old64 = '0;
        w_rd_ok    = (w_rd_idx < 32'(NUM_REGS));
        w_rd_sel   = '0;
        w_rd_data  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_idx == 32'(i)) begin
                w_wr_ok                       = !RO_MASK[i];
                w_wr_sel[i]                   = !RO_MASK[i];
                w_wr_old64[DATA_WIDTH-1:0]    = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (w_rd_idx == 32'(i)) begin
                w_rd_sel[i] = 1'b1;
                w_rd_data   = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_merged64 = strb_merge(w_wr_old64, w_wdata64, w_wstrb8);

    // Per-register storage: status registers pass reg_in straight through.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] r_reg;
            // Control register: byte-lane update on a committed write.
            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    r_reg <= RESET_VALUE;
                end else if (w_commit && w_wr_sel[gi]) begin
                    r_reg <= w_merged64[DATA_WIDTH-1:0];
                end
            end
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_reg;
        end
    end

    // Write response channel and write strobe generation.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? OKAY : SLVERR;
                if (w_wr_ok) begin
                    r_wr_pulse <= w_wr_sel;
                end
            end else if (r_bvalid && bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: sample on AR handshake, hold until rready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
            r_rd_pulse <= '0;
        end else begin
            r_rd_pulse <= '0;
            if (arvalid && arready) begin
                r_rvalid   <= 1'b1;
                r_rdata    <= w_rd_ok ? w_rd_data : '0;
                r_rresp    <= w_rd_ok ? OKAY : SLVERR;
                r_rd_pulse <= w_rd_sel;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign arready  = !r_rvalid;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign wr_pulse = r_wr_pulse;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign rd_pulse = r_rd_pulse;

    // Protection bits, status-only reg_in slices and widened upper bits are unused.
    assign w_unused = ^{awprot, arprot, reg_in, w_merged64, w_wdata64, w_aw_addr64, w_ar_addr64};

endmodule

// File: tb/tb_piradip_axilite_regfile.sv
// Directed bench for piradip_axilite_regfile: 16 x 32-bit registers,
// register 1 read-only. Inputs change 1 ns after the rising edge; outputs
// are sampled at that same point, well away from the next edge.
module tb_piradip_axilite_regfile;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;

    logic              aclk;
    logic              areset;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  reg_in;
    logic [NR-1:0]     wr_pulse;
    logic [NR-1:0]     rd_pulse;

    int checks = 0;
    int errors = 0;

    piradip_axilite_regfile #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .RO_MASK     (16'h0002),
        .RESET_VALUE (32'h0)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .reg_out  (reg_out),
        .reg_in   (reg_in),
        .wr_pulse (wr_pulse),
        .rd_pulse (rd_pulse)
    );

    // Clock and watchdog
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] reg_slice(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    // Present AW and W together; return right after the last handshake edge.
    task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int  n;
        logic hs_aw;
        logic hs_w;
        awaddr  = a;
        awvalid = 1'b1;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            step();
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            n++;
        end
        if (n >= 50) begin
            check("aw_w_timeout", 64'(n), 64'(0));
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    // Wait for the write response and check it together with the strobe.
    task automatic wait_b(input string tag, input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
        int n;
        n = 0;
        while (!bvalid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_bvalid"}, 64'(bvalid), 64'(1));
        check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        check({tag, "_wr_pulse"}, 64'(wr_pulse), 64'(exp_pulse));
        step();
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_data,
                           input logic [1:0] exp_resp, input logic [NR-1:0] exp_pulse);
        int n;
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            step();
            n++;
        end
        step();
        arvalid = 1'b0;
        check({tag, "_rvalid"}, 64'(rvalid), 64'(1));
        check({tag, "_rdata"}, 64'(rdata), 64'(exp_data));
        check({tag, "_rresp"}, 64'(rresp), 64'(exp_resp));
        check({tag, "_rd_pulse"}, 64'(rd_pulse), 64'(exp_pulse));
        step();
    endtask

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;
        reg_in  = '0;

        // Reset state
        #1;
        check("rst_awready", 64'(awready), 64'(1));
        check("rst_wready", 64'(wready), 64'(1));
        check("rst_arready", 64'(arready), 64'(1));
        check("rst_bvalid", 64'(bvalid), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_reg_out_or", 64'(|reg_out), 64'(0));
        check("rst_pulses", 64'({wr_pulse, rd_pulse}), 64'(0));
        step();
        step();
        areset = 1'b0;
        step();
        do_read("rd_reg0", 8'h00, 32'h0000_0000, 2'b00, 16'h0001);

        // W three cycles ahead of AW, full strobes to reg 2
        wdata  = 32'hDEAD_BEEF;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("w_first_wready", 64'(wready), 64'(0));
        check("w_first_no_b", 64'(bvalid), 64'(0));
        step();
        step();
        awaddr  = 8'h08;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("w_first_commit_cycle_bvalid", 64'(bvalid), 64'(0));
        step();
        check("w_first_bvalid", 64'(bvalid), 64'(1));
        check("w_first_bresp", 64'(bresp), 64'(0));
        check("w_first_wr_pulse", 64'(wr_pulse), 64'(16'h0004));
        check("w_first_reg2", 64'(reg_slice(2)), 64'(32'hDEAD_BEEF));
        step();
        check("w_first_pulse_gone", 64'(wr_pulse), 64'(0));
        check("w_first_b_gone", 64'(bvalid), 64'(0));

        // Partial strobe: low two lanes only
        send_aw_w(8'h08, 32'h1234_5678, 4'h3);
        wait_b("w_strb", 2'b00, 16'h0004);
        do_read("rd_strb", 8'h08, 32'hDEAD_5678, 2'b00, 16'h0004);

        // Read-only and out-of-range accesses
        send_aw_w(8'h04, 32'hFFFF_FFFF, 4'hF);
        wait_b("w_ro", 2'b10, 16'h0000);
        check("ro_reg1_out", 64'(reg_slice(1)), 64'(0));
        reg_in[1*DW +: DW] = 32'hA5A5_A5A5;
        #1;
        check("ro_reg1_passthru", 64'(reg_slice(1)), 64'(32'hA5A5_A5A5));
        do_read("rd_ro", 8'h04, 32'hA5A5_A5A5, 2'b00, 16'h0002);
        do_read("rd_oor", 8'h40, 32'h0000_0000, 2'b10, 16'h0000);
        send_aw_w(8'h40, 32'hCAFE_F00D, 4'hF);
        wait_b("w_oor", 2'b10, 16'h0000);
        do_read("rd_low_offset", 8'h0B, 32'hDEAD_5678, 2'b00, 16'h0004);

        // Write response backpressure
        bready = 1'b0;
        send_aw_w(8'h10, 32'h0000_0055, 4'hF);
        step();
        check("bp_first_pulse", 64'(wr_pulse), 64'(16'h0010));
        check("bp_reg4", 64'(reg_slice(4)), 64'(32'h55));
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_hold", 64'(bvalid), 64'(1));
            step();
        end
        send_aw_w(8'h14, 32'h0000_0066, 4'hF);
        check("bp_awready_low", 64'(awready), 64'(0));
        check("bp_wready_low", 64'(wready), 64'(0));
        step();
        step();
        check("bp_no_second_commit", 64'(reg_slice(5)), 64'(0));
        check("bp_no_second_pulse", 64'(wr_pulse), 64'(0));
        check("bp_still_bvalid", 64'(bvalid), 64'(1));
        bready = 1'b1;
        step();
        check("bp_b_released", 64'(bvalid), 64'(0));
        step();
        check("bp_second_bvalid", 64'(bvalid), 64'(1));
        check("bp_second_pulse", 64'(wr_pulse), 64'(16'h0020));
        check("bp_reg5", 64'(reg_slice(5)), 64'(32'h66));
        step();

        // Read data backpressure
        rready  = 1'b0;
        araddr  = 8'h10;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rbp_rvalid", 64'(rvalid), 64'(1));
            check("rbp_rdata", 64'(rdata), 64'(32'h55));
            check("rbp_arready", 64'(arready), 64'(0));
            step();
        end
        rready = 1'b1;
        step();
        check("rbp_rvalid_clear", 64'(rvalid), 64'(0));
        check("rbp_arready_back", 64'(arready), 64'(1));

        // Same-cycle commit and read of reg 3 returns the old value
        send_aw_w(8'h0C, 32'h0000_0022, 4'hF);
        wait_b("w_reg3_old", 2'b00, 16'h0008);
        send_aw_w(8'h0C, 32'h0000_0011, 4'hF);
        araddr  = 8'h0C;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("sim_rvalid", 64'(rvalid), 64'(1));
        check("sim_rdata_old", 64'(rdata), 64'(32'h22));
        check("sim_bvalid", 64'(bvalid), 64'(1));
        check("sim_reg3_new", 64'(reg_slice(3)), 64'(32'h11));
        step();
        do_read("sim_rd_new", 8'h0C, 32'h0000_0011, 2'b00, 16'h0008);

        // Reset in the middle of a write
        awaddr  = 8'h18;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("mid_aw_held", 64'(awready), 64'(0));
        areset = 1'b1;
        #1;
        check("mid_async_awready", 64'(awready), 64'(1));
        step();
        areset = 1'b0;
        step();
        step();
        check("mid_bvalid", 64'(bvalid), 64'(0));
        check("mid_awready", 64'(awready), 64'(1));
        check("mid_wready", 64'(wready), 64'(1));
        check("mid_arready", 64'(arready), 64'(1));
        check("mid_reg2_reset", 64'(reg_slice(2)), 64'(0));
        wdata  = 32'h0000_0077;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        step();
        step();
        check("mid_w_alone_no_b", 64'(bvalid), 64'(0));
        check("mid_reg6", 64'(reg_slice(6)), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
